// File: rtl/bmc_pkg.sv
// bmc_pkg: BMC state, interval-class and preamble types shared by the receiver and transmitter.
package bmc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_BIT, S_MID, S_PRE} state_t;
  typedef enum logic [2:0] {GLITCH, SHORT, LONG, MARK, OVER} ivl_t;
  typedef enum logic [1:0] {PRE_NONE, PRE_Z, PRE_X, PRE_Y} preamble_t;
  function automatic logic [1:0] ivl_halves(ivl_t c);
    return c == SHORT ? 2'd1 : c == LONG ? 2'd2 : 2'd3;
  endfunction
  function automatic preamble_t run_type(ivl_t c);
    return c == SHORT ? PRE_Z : c == MARK ? PRE_X : PRE_Y;
  endfunction
endpackage

// File: rtl/bmc_edge_sync.sv
// bmc_edge_sync: two-flop synchroniser for the raw BMC line plus transition detect.
module bmc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_edge
);
  logic r_s1, r_s2, r_prev;
  always_ff @(posedge clk)
    if (rst) {r_s1, r_s2, r_prev} <= '0;
    else {r_s1, r_s2, r_prev} <= {i_din, r_s1, r_s2};
  assign o_edge = r_s2 ^ r_prev;
endmodule

// File: rtl/bmc_receiver.sv
// bmc_receiver: biphase-mark decoder timing line transitions to recover bits and track lock.
// Define BMC_PREAMBLE_DETECT_EN to also decode 8-half-bit S/PDIF-style preambles.
module bmc_receiver #(
  parameter int HALF_BIT_CYCLES = 4,
  parameter int CNT_W = $clog2(4 * HALF_BIT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic       dout_valid,
  output logic       locked,
  output logic       err,
  output logic       preamble_valid,
  output logic [1:0] preamble_type
);
  import bmc_pkg::*;
  localparam int H = HALF_BIT_CYCLES;
  localparam logic [CNT_W-1:0] K_SHORT = CNT_W'(H / 2);
  localparam logic [CNT_W-1:0] K_LONG = CNT_W'(3 * H / 2);
  localparam logic [CNT_W-1:0] K_MARK = CNT_W'(5 * H / 2);
  localparam logic [CNT_W-1:0] K_OVER = CNT_W'(7 * H / 2);
`ifdef BMC_PREAMBLE_DETECT_EN
  localparam logic [CNT_W-1:0] K_TO = K_OVER;
  logic [3:0] r_sum, w_sum_nxt;
  preamble_t r_pend, w_pend_nxt, r_ptype;
  logic r_pre_valid, w_pre_done;
`else
  localparam logic [CNT_W-1:0] K_TO = K_MARK;
`endif
  logic w_edge, w_evt, w_emit, w_bad, w_lock;
  logic r_dout, r_valid, r_locked, r_err;
  logic [CNT_W-1:0] r_cnt;
  state_t r_state, w_state_nxt;
  ivl_t w_cls;
  bmc_edge_sync u_sync (.clk(clk), .rst(rst), .i_din(din), .o_edge(w_edge));
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (w_edge) r_cnt <= CNT_W'(1);
    else if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  // A silent line is classed OVER the single cycle the counter reaches the timeout.
  assign w_evt = w_edge || r_cnt == K_TO;
  assign w_cls = !w_edge ? OVER : r_cnt < K_SHORT ? GLITCH : r_cnt < K_LONG ? SHORT :
                 r_cnt < K_MARK ? LONG : r_cnt < K_OVER ? MARK : OVER;
  always_comb begin
    w_state_nxt = r_state;
    w_emit = 1'b0;
    w_bad = 1'b0;
    w_lock = r_locked;
`ifdef BMC_PREAMBLE_DETECT_EN
    w_sum_nxt = r_sum;
    w_pend_nxt = r_pend;
    w_pre_done = 1'b0;
`endif
    if (w_evt)
      case (r_state)
        S_IDLE: w_state_nxt = w_edge ? S_ACQ : S_IDLE;
        S_ACQ, S_BIT: begin
          if (w_cls == LONG) begin
            w_emit = 1'b1;
            w_lock = 1'b1;
            w_state_nxt = S_BIT;
          end else if (w_cls == SHORT) w_state_nxt = r_state == S_BIT ? S_MID : S_ACQ;
`ifdef BMC_PREAMBLE_DETECT_EN
          else if (w_cls == MARK) begin
            w_sum_nxt = 4'd3;
            w_state_nxt = S_PRE;
          end
`endif
          else w_bad = 1'b1;
        end
        S_MID: begin
          w_emit = w_cls == SHORT;
          w_bad = w_cls != SHORT;
          w_state_nxt = S_BIT;
        end
        default: begin
`ifdef BMC_PREAMBLE_DETECT_EN
          if (w_cls == GLITCH || w_cls == OVER) w_bad = 1'b1;
          else begin
            w_sum_nxt = r_sum + {2'b00, ivl_halves(w_cls)};
            if (r_sum == 4'd3) w_pend_nxt = run_type(w_cls);
            if (w_sum_nxt == 4'd8) begin
              w_pre_done = 1'b1;
              w_lock = 1'b1;
              w_state_nxt = S_BIT;
            end else if (w_sum_nxt > 4'd8) w_bad = 1'b1;
          end
`else
          w_bad = 1'b1;
`endif
        end
      endcase
    if (w_bad) begin
      w_lock = 1'b0;
      w_state_nxt = (w_cls == OVER || (r_state == S_ACQ && w_cls == GLITCH)) ? S_IDLE : S_ACQ;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_locked <= 1'b0;
      r_dout <= 1'b0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_locked <= w_lock;
      r_valid <= w_emit;
      r_err <= w_bad && r_locked;
      if (w_emit) r_dout <= r_state == S_MID;
    end
  assign dout = r_dout;
  assign dout_valid = r_valid;
  assign locked = r_locked;
  assign err = r_err;
`ifdef BMC_PREAMBLE_DETECT_EN
  always_ff @(posedge clk)
    if (rst) begin
      r_sum <= '0;
      r_pend <= PRE_NONE;
      r_ptype <= PRE_NONE;
      r_pre_valid <= 1'b0;
    end else begin
      r_sum <= w_sum_nxt;
      r_pend <= w_pend_nxt;
      r_pre_valid <= w_pre_done;
      if (w_pre_done) r_ptype <= w_pend_nxt;
    end
  assign preamble_valid = r_pre_valid;
  assign preamble_type = r_ptype;
`else
  assign preamble_valid = 1'b0;
  assign preamble_type = 2'd0;
`endif
endmodule

// File: tb/tb_bmc_receiver.sv
// tb_bmc_receiver: BMC-encodes random and fixed bit streams and checks the decoder against a bit-level model.
module tb_bmc_receiver;
  localparam int H = 4;
  typedef logic bq_t[$];
  logic clk = 1'b0, rst = 1'b1, din = 1'b0;
  logic dout, dout_valid, locked, err, preamble_valid;
  logic [1:0] preamble_type;
  int checks = 0, errors = 0, err_cnt = 0, pv_cnt = 0;
  bq_t got;
  logic [1:0] ptypes[$];
  bmc_receiver #(.HALF_BIT_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .dout_valid(dout_valid), .locked(locked),
    .err(err), .preamble_valid(preamble_valid), .preamble_type(preamble_type)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (dout_valid) got.push_back(dout);
    if (err) err_cnt++;
    if (preamble_valid) begin
      pv_cnt++;
      ptypes.push_back(preamble_type);
    end
  end
  function automatic logic [63:0] pack(input bq_t q);
    logic [63:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction
  // Decoder output is every transmitted bit from the first 0 (first LONG interval) onwards.
  function automatic bq_t model(input bq_t bits);
    bq_t q;
    bit seen = 1'b0;
    foreach (bits[i]) begin
      if (!bits[i]) seen = 1'b1;
      if (seen) q.push_back(bits[i]);
    end
    return q;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic run(input int halves);
    din = ~din;
    tick(halves * H + int'($urandom_range(2)) - 1);
  endtask
  task automatic send(input bq_t bits);
    foreach (bits[i])
      if (bits[i]) begin
        run(1);
        run(1);
      end else run(2);
  endtask
  task automatic drive_pattern(input logic [7:0] p);
    int len = 1;
    for (int i = 6; i >= 0; i--)
      if (p[i] == p[i+1]) len++;
      else begin
        run(len);
        len = 1;
      end
    run(len);
  endtask
  task automatic close_line();
    din = ~din;
    tick(5);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(24);
    got.delete();
    ptypes.delete();
    err_cnt = 0;
    pv_cnt = 0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({dout, dout_valid, locked, err, preamble_valid, preamble_type} !== 7'b0) begin
      errors++;
      $display("FAIL reset outputs: got %b want 0000000", {dout, dout_valid, locked, err, preamble_valid, preamble_type});
    end
    do_reset();
  endtask
  task automatic test_basic();
    bq_t bits, exp;
    do_reset();
    bits = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp = model(bits);
    send(bits);
    close_line();
    checks++;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++;
      $display("FAIL basic strobes: got %0d bits %h want %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
    checks++;
    if (locked !== 1'b1 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic lock: locked %b errs %0d want 1 0", locked, err_cnt);
    end
  endtask
  task automatic test_idle_over();
    tick(25);
    checks++;
    if (err_cnt != 1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL idle over: errs %0d locked %b want 1 0", err_cnt, locked);
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      bq_t bits, exp;
      do_reset();
      for (int i = $urandom_range(30, 12); i > 0; i--) bits.push_back(1'($urandom_range(1)));
      bits[$urandom_range(5)] = 1'b0;
      exp = model(bits);
      send(bits);
      close_line();
      checks++;
      if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
        errors++;
        $display("FAIL random strobes %0d: got %0d bits %h want %0d bits %h", it, got.size(), pack(got), exp.size(), pack(exp));
      end
      checks++;
      if (dout !== bits[bits.size()-1] || locked !== 1'b1 || err_cnt != 0) begin
        errors++;
        $display("FAIL random hold %0d: dout %b locked %b errs %0d want %b 1 0", it, dout, locked, err_cnt, bits[bits.size()-1]);
      end
      tick(25);
      checks++;
      if (err_cnt != 1 || locked !== 1'b0) begin
        errors++;
        $display("FAIL random timeout %0d: errs %0d locked %b want 1 0", it, err_cnt, locked);
      end
    end
  endtask
  task automatic test_glitch();
    bq_t bits, exp;
    int g;
    do_reset();
    bits = {1'b0, 1'b0, 1'b1, 1'b0};
    exp = model(bits);
    send(bits);
    g = $urandom_range(3, 1);
    din = ~din;
    tick(g);
    din = ~din;
    tick(1);
    din = ~din;
    tick(30);
    checks++;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++;
      $display("FAIL glitch strobes: got %0d bits %h want %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
    checks++;
    if (err_cnt != 1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL glitch err: errs %0d locked %b want 1 0", err_cnt, locked);
    end
  endtask
  task automatic test_rst_mid_bit();
    bq_t bits, exp;
    do_reset();
    bits = {1'b0, 1'b0};
    send(bits);
    run(1);
    din = ~din;
    tick(3);
    checks++;
    if (locked !== 1'b1 || got.size() != 2 || pack(got) !== 64'd0) begin
      errors++;
      $display("FAIL pre-reset: locked %b strobes %0d want 1 2", locked, got.size());
    end
    got.delete();
    rst = 1'b1;
    tick(1);
    checks++;
    if ({dout, dout_valid, locked, err, preamble_valid, preamble_type} !== 7'b0) begin
      errors++;
      $display("FAIL mid-bit reset outputs: got %b want 0000000", {dout, dout_valid, locked, err, preamble_valid, preamble_type});
    end
    rst = 1'b0;
    tick(24);
    bits = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp = model(bits);
    send(bits);
    close_line();
    checks++;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++;
      $display("FAIL reacquire strobes: got %0d bits %h want %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
  endtask
`ifdef BMC_PREAMBLE_DETECT_EN
  task automatic test_preamble();
    bq_t lead, data, exp;
    logic [7:0] pats[3] = '{8'b11101000, 8'b11100010, 8'b11100100};
    do_reset();
    lead = {1'b0, 1'b0};
    data = {1'b1, 1'b0};
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    send(lead);
    for (int i = 0; i < 3; i++) begin
      drive_pattern(pats[i]);
      send(data);
    end
    close_line();
    checks++;
    if (got.size() != exp.size() || pack(got) !== pack(exp)) begin
      errors++;
      $display("FAIL preamble strobes: got %0d bits %h want %0d bits %h", got.size(), pack(got), exp.size(), pack(exp));
    end
    checks++;
    if (pv_cnt != 3 || err_cnt != 0) begin
      errors++;
      $display("FAIL preamble count: valid %0d errs %0d want 3 0", pv_cnt, err_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ptypes.size() || ptypes[i] !== 2'(i + 1)) begin
        errors++;
        $display("FAIL preamble type %0d: got %0d want %0d", i, i < ptypes.size() ? ptypes[i] : 2'd0, i + 1);
      end
    end
    checks++;
    if (preamble_type !== 2'd3) begin
      errors++;
      $display("FAIL preamble hold: got %0d want 3", preamble_type);
    end
  endtask
`else
  task automatic test_no_preamble();
    bq_t lead, data;
    do_reset();
    lead = {1'b0, 1'b0};
    data = {1'b1, 1'b0};
    send(lead);
    drive_pattern(8'b11101000);
    send(data);
    close_line();
    checks++;
    if (err_cnt != 1) begin
      errors++;
      $display("FAIL no-preamble err: got %0d want 1", err_cnt);
    end
    checks++;
    if (pv_cnt != 0 || preamble_type !== 2'd0) begin
      errors++;
      $display("FAIL no-preamble outputs: valid %0d type %0d want 0 0", pv_cnt, preamble_type);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_idle_over();
    test_random();
    test_glitch();
    test_rst_mid_bit();
`ifdef BMC_PREAMBLE_DETECT_EN
    test_preamble();
`else
    test_no_preamble();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
